// File: rtl/core_ifu_imem_responder_pkg.sv
// Shared types and widths for the IFU instruction-memory responder.
//   Build-wide macros (normally from core_defines.v) are given fallback values
//   here so the slice builds stand-alone:
//     CORE_PC_WIDTH, CORE_INST_WIDTH   existing core widths
//     CORE_IMEM_AW_DFLT                default word-address width of the array
//     CORE_IMEM_ERR_INST               instruction returned with an access fault
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif
`ifndef CORE_IMEM_AW_DFLT
`define CORE_IMEM_AW_DFLT 12
`endif
`ifndef CORE_IMEM_ERR_INST
`define CORE_IMEM_ERR_INST 32'h0
`endif

package core_ifu_imem_responder_pkg;

  localparam int PC_W         = `CORE_PC_WIDTH;
  localparam int INST_W       = `CORE_INST_WIDTH;
  localparam int IMEM_AW_DFLT = `CORE_IMEM_AW_DFLT;
  localparam logic [INST_W-1:0] ERR_INST = `CORE_IMEM_ERR_INST;

  // One fetch response as it travels through the stage pipe and FIFO.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              err;
  } imem_rsp_t;

  // Any byte-address bit above the array's word index means out of range.
  function automatic logic pc_out_of_range(input logic [PC_W-1:0] pc, input int aw);
    return (pc >> (aw + 2)) != '0;
  endfunction

endpackage

// File: rtl/core_ifu_imem_rsp_fifo.sv
// Response FIFO for the instruction-memory responder.
//   Synchronous FIFO of DEPTH fetch responses with a show-ahead head.
//   Ports:
//     clk, rst_n        clock, async active-low reset (pointers only)
//     clr               synchronous clear, wins over write and read
//     wr_en, wr_data    enqueue one response
//     rd_en             dequeue the head
//     rd_data           current head (valid when !empty)
//     empty             no entry present
module core_ifu_imem_rsp_fifo
  import core_ifu_imem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      wr_en,
  input  imem_rsp_t wr_data,
  input  logic      rd_en,
  output imem_rsp_t rd_data,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  // Extra wrap bit distinguishes full from empty.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  imem_rsp_t   mem [DEPTH];
  logic        full;
  logic        wr_fire;
  logic        rd_fire;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign wr_fire = wr_en && !full && !clr;
  assign rd_fire = rd_en && !empty && !clr;
  assign rd_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[PW-1:0]] <= wr_data;
  end

  // Credit accounting upstream must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !clr));

endmodule

// File: rtl/core_ifu_imem_responder.sv
// Instruction-memory responder on the far side of the IFU fetch port.
//   Accepts PC fetch requests and returns {inst, pc, err} strictly in order
//   after a fixed LATENCY (1..4). At most OSTD fetches are outstanding, which
//   is also the response FIFO depth. flush drops everything in flight.
//   Optional feature macro: CORE_IMEM_MISALIGN_CHK_EN (fault on pc[1:0] != 0;
//   when undefined the low PC bits are ignored).
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     req_valid/req_ready/req_pc      fetch request channel
//     rsp_valid/rsp_ready             response channel (FIFO head)
//     rsp_inst/rsp_pc/rsp_err         response payload, zero when !rsp_valid
//     flush                           discard all outstanding fetches
//     ld_wen/ld_addr/ld_data          array load port (word addressed)
module core_ifu_imem_responder
  import core_ifu_imem_responder_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DFLT,
  parameter int LATENCY = 2,
  parameter int OSTD    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [PC_W-1:0]    req_pc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INST_W-1:0]  rsp_inst,
  output logic [PC_W-1:0]    rsp_pc,
  output logic               rsp_err,
  input  logic               flush,
  input  logic               ld_wen,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [INST_W-1:0]  ld_data
);

  localparam int CNT_W = $clog2(OSTD + 1);

  logic [INST_W-1:0]  mem [2**IMEM_AW];
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               deq;
  logic [IMEM_AW-1:0] widx;
  logic               addr_err;
  imem_rsp_t          rd_ent;
  logic               fifo_wr_en;
  imem_rsp_t          fifo_wr_data;
  imem_rsp_t          head;
  logic               fifo_empty;

  assign req_ready = !flush && (cnt < CNT_W'(OSTD));
  assign accept    = req_valid && req_ready;
  assign deq       = rsp_valid && rsp_ready;
  assign widx      = req_pc[IMEM_AW+1:2];

  always_comb begin
    rd_ent   = '0;
    addr_err = pc_out_of_range(req_pc, IMEM_AW);
`ifdef CORE_IMEM_MISALIGN_CHK_EN
    if (req_pc[1:0] != 2'b00) addr_err = 1'b1;
`endif
    rd_ent.pc   = req_pc;
    rd_ent.err  = addr_err;
    rd_ent.inst = addr_err ? ERR_INST : mem[widx];
  end

  // Load port. The fetch read samples mem before this write lands, so a
  // same-word collision returns the old contents.
  always_ff @(posedge clk) begin
    if (ld_wen) mem[ld_addr] <= ld_data;
  end

  generate
    if (LATENCY == 1) begin : g_nopipe
      // The FIFO entry itself is the registered read.
      assign fifo_wr_en   = accept;
      assign fifo_wr_data = rd_ent;
    end else begin : g_pipe
      logic [LATENCY-2:0] stg_v;
      imem_rsp_t          stg_d [LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_v <= '0;
        end else if (flush) begin
          stg_v <= '0;
        end else begin
          stg_v[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) stg_v[i] <= stg_v[i-1];
        end
      end

      always_ff @(posedge clk) begin
        stg_d[0] <= rd_ent;
        for (int i = 1; i < LATENCY - 1; i++) stg_d[i] <= stg_d[i-1];
      end

      assign fifo_wr_en   = stg_v[LATENCY-2];
      assign fifo_wr_data = stg_d[LATENCY-2];
    end
  endgenerate

  // Outstanding = accepted and not yet dequeued; covers pipe and FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept && !deq) begin
      cnt <= cnt + 1'b1;
    end else if (deq && !accept) begin
      cnt <= cnt - 1'b1;
    end
  end

  core_ifu_imem_rsp_fifo #(.DEPTH(OSTD)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (deq),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_inst  = rsp_valid ? head.inst : '0;
  assign rsp_pc    = rsp_valid ? head.pc   : '0;
  assign rsp_err   = rsp_valid && head.err;

endmodule
